// File: rtl/led_show_pkg.sv
// Shared constants for the light-show controller: state codes, default
// period select and RGB level width.
package led_show_pkg;
  localparam int LEVEL_W = 15;

  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_FREEZE  = 2'd2;
  localparam logic [1:0] S_RESTART = 2'd3;

  localparam logic [1:0] PERIOD_DEFAULT = 2'd2;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw push button.
// rise/fall are one-cycle pulses registered together with the level flip.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed from the stable one long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        rise  <= ~level;
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/led_show_ctrl.sv
// Button-driven sequencer for the RGB light-show generator: debounces the
// mode and speed buttons, classifies mode presses as short or long, and
// drives generator reset, period select and the gated RGB levels.
module led_show_ctrl
  import led_show_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 1_000_000,
  parameter int HOLD_TICKS     = 100_000_000,
  parameter int RESTART_TICKS  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         btn,
  input  logic [LEVEL_W-1:0] red_in,
  input  logic [LEVEL_W-1:0] green_in,
  input  logic [LEVEL_W-1:0] blue_in,
  output logic               gen_rst,
  output logic [1:0]         period_sel,
  output logic [LEVEL_W-1:0] red,
  output logic [LEVEL_W-1:0] green,
  output logic [LEVEL_W-1:0] blue,
  output logic [1:0]         state_dbg
);
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam int RCNT_W = (RESTART_TICKS > 1) ? $clog2(RESTART_TICKS) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESTART_TICKS - 1);

  logic              mode_lvl, mode_rise, mode_fall;
  logic              speed_lvl, speed_rise, speed_fall;
  logic              unused_edges;
  logic [HOLD_W-1:0] hold_cnt;
  logic              suppress;
  logic              long_evt, short_evt, speed_evt, to_off;
  logic [1:0]        state;
  logic [RCNT_W-1:0] restart_cnt;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_mode_db (
    .clk(clk), .rst(rst), .raw(btn[0]),
    .level(mode_lvl), .rise(mode_rise), .fall(mode_fall)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_speed_db (
    .clk(clk), .rst(rst), .raw(btn[1]),
    .level(speed_lvl), .rise(speed_rise), .fall(speed_fall)
  );

  assign unused_edges = ^{mode_rise, speed_lvl, speed_fall};

  // Hold counter saturates, so suppress keeps the long event to a single cycle.
  assign long_evt  = mode_lvl && (hold_cnt == HOLD_LAST) && !suppress;
  assign short_evt = mode_fall && !suppress;
  assign speed_evt = speed_rise;
  assign to_off    = ((state == S_RUN) || (state == S_FREEZE)) && long_evt;
  assign state_dbg = state;

  // Measure how long the mode button has been held; a long press masks its release.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      suppress <= 1'b0;
    end else begin
      if (!mode_lvl)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      if (long_evt)
        suppress <= 1'b1;
      else if (mode_fall)
        suppress <= 1'b0;
    end
  end

  // Show sequencer; mode-button events take priority over the speed button.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESTART;
      restart_cnt <= '0;
      gen_rst     <= 1'b1;
      period_sel  <= PERIOD_DEFAULT;
    end else begin
      case (state)
        S_OFF: begin
          if (short_evt) begin
            state       <= S_RUN;
            restart_cnt <= '0;
            gen_rst     <= 1'b0;
          end else if (!long_evt && speed_evt) begin
            period_sel <= period_sel + 2'd1;
          end
        end
        S_RUN, S_FREEZE: begin
          if (long_evt) begin
            state   <= S_OFF;
            gen_rst <= 1'b1;
          end else if (short_evt) begin
            state <= (state == S_RUN) ? S_FREEZE : S_RUN;
          end else if (speed_evt) begin
            period_sel  <= period_sel + 2'd1;
            state       <= S_RESTART;
            restart_cnt <= '0;
            gen_rst     <= 1'b1;
          end
        end
        default: begin
          if (restart_cnt == RCNT_LAST) begin
            state       <= S_RUN;
            restart_cnt <= '0;
            gen_rst     <= 1'b0;
          end else begin
            restart_cnt <= restart_cnt + RCNT_W'(1);
          end
        end
      endcase
    end
  end

  // Gate the generator levels: track in RUN, hold otherwise, blank when off.
  always_ff @(posedge clk) begin
    if (rst || to_off) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (state == S_RUN) begin
      red   <= red_in;
      green <= green_in;
      blue  <= blue_in;
    end
  end
endmodule

// File: tb/tb_led_show_ctrl.sv
// Bench for led_show_ctrl: directed button scenarios followed by random
// button activity, with every cycle compared against a behavioural model.
module tb_led_show_ctrl;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  btn;
  logic [14:0] red_in, green_in, blue_in;
  logic        gen_rst;
  logic [1:0]  period_sel;
  logic [14:0] red, green, blue;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  // Model state: raw history, stable levels, mismatch run lengths, pulses.
  int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_rise[2], m_fall[2];
  int m_highc, m_prevrun;
  int m_state, m_rleft, m_gen, m_per, m_r, m_g, m_b;

  led_show_ctrl #(.DEBOUNCE_TICKS(D), .HOLD_TICKS(H), .RESTART_TICKS(R)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .gen_rst(gen_rst), .period_sel(period_sel),
    .red(red), .green(green), .blue(blue), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step(input int r, input int b0, input int b1,
                            input int ri, input int gi, input int bi);
    int long_e, short_e, press_e, old_state, old_l0;
    int raw[2];
    if (r != 0) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
        m_rise[i] = 0; m_fall[i] = 0;
      end
      m_highc = 0; m_prevrun = 0;
      m_state = 3; m_rleft = R; m_gen = 1; m_per = 2;
      m_r = 0; m_g = 0; m_b = 0;
      return;
    end
    long_e  = (m_lvl[0] == 1 && m_highc == H) ? 1 : 0;
    short_e = (m_fall[0] == 1 && m_prevrun < H) ? 1 : 0;
    press_e = m_rise[1];
    old_state = m_state;
    case (m_state)
      0: begin
        if (short_e != 0) begin m_state = 1; m_gen = 0; end
        else if (long_e == 0 && press_e != 0) m_per = (m_per + 1) % 4;
      end
      1, 2: begin
        if (long_e != 0) begin m_state = 0; m_gen = 1; end
        else if (short_e != 0) m_state = (m_state == 1) ? 2 : 1;
        else if (press_e != 0) begin
          m_per = (m_per + 1) % 4; m_state = 3; m_gen = 1; m_rleft = R;
        end
      end
      default: begin
        m_rleft--;
        if (m_rleft == 0) begin m_state = 1; m_gen = 0; end
      end
    endcase
    if (m_state == 0) begin
      m_r = 0; m_g = 0; m_b = 0;
    end else if (old_state == 1) begin
      m_r = ri; m_g = gi; m_b = bi;
    end
    old_l0 = m_lvl[0];
    raw[0] = b0; raw[1] = b1;
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0; m_fall[i] = 0;
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i]  = 1 - m_lvl[i];
          m_rise[i] = m_lvl[i];
          m_fall[i] = 1 - m_lvl[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    if (m_lvl[0] == 1) begin
      m_highc = (old_l0 == 1) ? ((m_highc < H + 1) ? m_highc + 1 : m_highc) : 1;
    end else if (old_l0 == 1) begin
      m_prevrun = m_highc;
      m_highc = 0;
    end
  endtask

  task automatic tick();
    red_in   = 15'($urandom);
    green_in = 15'($urandom);
    blue_in  = 15'($urandom);
    @(posedge clk);
    model_step(int'(rst), int'(btn[0]), int'(btn[1]),
               int'(red_in), int'(green_in), int'(blue_in));
    #1;
    check_val("state", int'(state_dbg), m_state);
    check_val("gen_rst", int'(gen_rst), m_gen);
    check_val("period_sel", int'(period_sel), m_per);
    check_val("red", int'(red), m_r);
    check_val("green", int'(green), m_g);
    check_val("blue", int'(blue), m_b);
  endtask

  task automatic run(input logic b0, input logic b1, input int n);
    btn = {b1, b0};
    repeat (n) tick();
  endtask

  initial begin
    int exp_per[4];
    int dur;
    exp_per[0] = 3; exp_per[1] = 0; exp_per[2] = 1; exp_per[3] = 2;
    rst = 1'b1;
    btn = 2'b00;
    run(1'b0, 1'b0, 2);
    check_val("reset_state", int'(state_dbg), 3);
    check_val("reset_gen_rst", int'(gen_rst), 1);
    check_val("reset_period", int'(period_sel), 2);
    check_val("reset_red", int'(red), 0);
    rst = 1'b0;
    run(1'b0, 1'b0, 6);
    check_val("release_run", int'(state_dbg), 1);
    check_val("release_period", int'(period_sel), 2);

    // Glitch shorter than the debounce window.
    run(1'b1, 1'b0, 3);
    run(1'b0, 1'b0, 10);
    check_val("glitch_ignored", int'(state_dbg), 1);

    // Short press freezes, another resumes.
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 10);
    check_val("short_freeze", int'(state_dbg), 2);
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 10);
    check_val("short_resume", int'(state_dbg), 1);

    // Long press turns the show off; its release is not a short press.
    run(1'b1, 1'b0, 30);
    check_val("long_off", int'(state_dbg), 0);
    check_val("long_red", int'(red), 0);
    check_val("long_gen_rst", int'(gen_rst), 1);
    run(1'b0, 1'b0, 10);
    check_val("long_release", int'(state_dbg), 0);

    // Short press from off starts the show.
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 10);
    check_val("off_to_run", int'(state_dbg), 1);
    check_val("off_to_run_gen", int'(gen_rst), 0);

    // Four speed presses wrap the period select.
    for (int i = 0; i < 4; i++) begin
      run(1'b0, 1'b1, 8);
      run(1'b0, 1'b0, 12);
      check_val("speed_period", int'(period_sel), exp_per[i]);
      check_val("speed_state", int'(state_dbg), 1);
    end

    // Mode release and speed press land on the same cycle.
    run(1'b1, 1'b0, 8);
    run(1'b0, 1'b1, 8);
    run(1'b0, 1'b0, 12);
    check_val("collide_state", int'(state_dbg), 2);
    check_val("collide_period", int'(period_sel), 2);

    // Mode release lands inside a restart pulse and is discarded.
    run(1'b1, 1'b0, 8);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 10);
    run(1'b0, 1'b0, 12);
    check_val("discard_state", int'(state_dbg), 1);
    check_val("discard_period", int'(period_sel), 3);

    // Reset while frozen.
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 10);
    check_val("pre_rst_freeze", int'(state_dbg), 2);
    rst = 1'b1;
    tick();
    check_val("mid_rst_state", int'(state_dbg), 3);
    check_val("mid_rst_red", int'(red), 0);
    check_val("mid_rst_period", int'(period_sel), 2);
    check_val("mid_rst_gen", int'(gen_rst), 1);
    rst = 1'b0;
    run(1'b0, 1'b0, 6);

    // Random button activity with occasional resets.
    for (int k = 0; k < 60; k++) begin
      dur = int'($urandom_range(1, 30));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dur);
    end
    run(1'b0, 1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_show_ctrl.md
# led_show_ctrl

User-facing controller for the RGB light-show generator on the Arty S7. It debounces two push buttons and sequences the generator through run, freeze, off and restart. It drives the generator's reset and period select, and gates the generator's 15-bit RGB levels before they reach the PWM stage.

## Interface
Parameters:
- DEBOUNCE_TICKS, 1_000_000: consecutive stable cycles before a button level is accepted (10 ms at 100 MHz).
- HOLD_TICKS, 100_000_000: debounced btn[0] high time that counts as a long press (1 s).
- RESTART_TICKS, 16: width of the gen_rst pulse in S_RESTART.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn  in  2  raw asynchronous buttons; [0] = mode, [1] = speed.
- red_in, green_in, blue_in  in  15 each  generator levels.
- gen_rst  out  1  generator reset.
- period_sel  out  2  generator period select.
- red, green, blue  out  15 each  gated levels to PWM.
- state_dbg  out  2  current state encoding.

## Operation
- Input path, per button:
  - 2-FF synchronizer.
  - Debounce counter: clears whenever the synced level equals the stable level; otherwise increments. When the count reaches DEBOUNCE_TICKS - 1, the stable level flips and the counter clears.
- btn[0] hold counter (saturating):
  - Runs while stable btn[0] = 1; clears on release.
  - Reaching HOLD_TICKS - 1 fires a one-cycle long event and sets a suppress flag.
  - Release (stable 1->0) fires a short event only if suppress = 0. Suppress clears on release.
- btn[1]: press event on stable 0->1.
- States (encoding in package): S_OFF = 0, S_RUN = 1, S_FREEZE = 2, S_RESTART = 3.
  - S_OFF:
    - short -> S_RUN, with restart counter loaded so gen_rst drops cleanly.
    - btn[1] press -> period_sel += 1 (wraps 3->0); state unchanged.
    - gen_rst = 1; RGB = 0.
  - S_RUN:
    - short -> S_FREEZE.
    - long -> S_OFF.
    - btn[1] press -> period_sel += 1, go S_RESTART.
    - RGB = registered copy of inputs.
  - S_FREEZE:
    - short -> S_RUN.
    - long -> S_OFF.
    - btn[1] press -> period_sel += 1, go S_RESTART.
    - RGB held; gen_rst = 0, so the generator keeps running underneath.
  - S_RESTART:
    - gen_rst = 1 for exactly RESTART_TICKS cycles, then -> S_RUN.
    - RGB held at last value.
    - All button events are discarded; hold/suppress logic keeps tracking.
- Simultaneous events: long beats short, which cannot coincide anyway. A btn[0] event beats a btn[1] press in the same cycle; the btn[1] event is dropped, not queued.
- period_sel wraps 3->0; no saturation.
- Bad state encoding is unreachable with a 2-bit state; all four codes are legal.

## Timing
- Reset values while rst = 1 and on the first cycle after:
  - state = S_RESTART, restart counter = 0, gen_rst = 1, period_sel = 2.
  - red = green = blue = 0; debounce, hold and suppress all 0.
- After rst deasserts:
  - gen_rst stays high for RESTART_TICKS cycles, then S_RUN.
  - RGB is 0 until the first RUN-registered sample.
- Button latency: raw edge to event is 2 (sync) + DEBOUNCE_TICKS cycles. The state/period_sel update is registered on the next edge.
- gen_rst and period_sel are registered. period_sel changes on the same edge the state enters S_RESTART, so it is stable throughout gen_rst.
- RGB in S_RUN: 1-cycle latency from *_in.
- Leaving S_FREEZE/S_RESTART for S_RUN: outputs track inputs starting the cycle after entry.
- rst mid-operation overrides everything on that edge.

## Structure
- Package led_show_pkg:
  - State localparams.
  - Default period_sel = 2.
  - Level width 15.
- Sub-module btn_debounce (parameter DEBOUNCE_TICKS; ports clk, rst, raw, level, rise, fall), instantiated twice.
- The hold counter and FSM stay in the top module.

## Test plan
Bench parameters: DEBOUNCE_TICKS = 4, HOLD_TICKS = 20, RESTART_TICKS = 3.
- Reset release:
  - gen_rst high for exactly 3 cycles, then state_dbg = 1.
  - period_sel = 2; RGB tracks *_in one cycle late.
- Glitch rejection:
  - btn[0] high 3 cycles then low -> no state change.
  - High 10 cycles then low -> S_FREEZE; RGB frozen while *_in ramps.
- Long press:
  - btn[0] high 30 cycles in S_RUN -> S_OFF at the 20th stable-high cycle; RGB = 0; gen_rst = 1.
  - Release produces no event.
- Speed wrap:
  - Four btn[1] presses from S_RUN -> period_sel 3, 0, 1, 2.
  - Each press gives a 3-cycle gen_rst pulse; RGB held during each pulse.
- Collision and discard:
  - btn[0] release and btn[1] press debounced on the same cycle in S_RUN -> S_FREEZE, period_sel unchanged.
  - btn[1] press during S_RESTART -> ignored.
- Reset mid-S_FREEZE -> S_RESTART, outputs 0, period_sel = 2.
